// File: rtl/perceptron_mac.sv
// perceptron_mac
// ----------------------------------------------------------------------------
// Sequential multiply-accumulate stage for one perceptron. An operation starts
// by loading the bias (aligned to the product scale) into a wide accumulator.
// It then accepts NINPUTS signed fixed-point (x, w) pairs over a valid/ready
// stream and adds each full-precision product to the accumulator. Finally it
// emits the weighted sum with a one-cycle out_valid strobe. out_data feeds the
// neuron output register's data input and out_valid feeds its enable.
//
// Optional feature macro: PERCEPTRON_MAC_SAT_EN
//   defined     : result clamped to the signed DWIDTH range, sat flags a clamp
//   not defined : result is the low DWIDTH bits (wrap-around), sat tied to 0
//
// Parameters:
//   DWIDTH  - width of x, w, bias and result (signed two's complement)
//   FRAC    - fractional bits of the Q(DWIDTH-FRAC).FRAC format
//   NINPUTS - number of (x, w) pairs per operation (>= 1)
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   reset     in   synchronous, active-high reset
//   start     in   begin an operation (only looked at while idle)
//   bias      in   bias value, captured on the edge that accepts start
//   in_valid  in   in_x / in_w hold a valid pair
//   in_ready  out  stage accepts a pair this cycle
//   in_x      in   neuron input
//   in_w      in   weight
//   out_data  out  result, held until the next result
//   out_valid out  one-cycle strobe marking a new result
//   busy      out  high whenever an operation is in progress
//   sat       out  current out_data was clamped
// ----------------------------------------------------------------------------
module perceptron_mac #(
    parameter int DWIDTH  = 32,
    parameter int FRAC    = 16,
    parameter int NINPUTS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DWIDTH-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_x,
    input  logic [DWIDTH-1:0] in_w,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              sat
);

    localparam int PW   = 2 * DWIDTH;
    localparam int ACCW = 2 * DWIDTH + $clog2(NINPUTS) + 1;
    localparam int CW   = $clog2(NINPUTS + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DRAIN,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           beat_cnt;
    logic signed [PW-1:0]    prod;
    logic                    prod_valid;
    logic signed [ACCW-1:0]  acc;
    logic signed [ACCW-1:0]  shifted;
    logic [DWIDTH-1:0]       result;
    logic                    result_sat;
    logic                    beat;
    logic                    last_beat;

    // A beat is a pair transferred on this edge; the last one is the beat
    // that brings the count up to NINPUTS.
    assign beat      = in_valid & in_ready;
    assign last_beat = beat && (beat_cnt == CW'(NINPUTS - 1));

    // Next-state and handshake decode. in_ready and busy come straight from
    // the state so they are low out of reset without extra registers.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: one product register stage, then the accumulator. The bias is
    // shifted up by FRAC so it sits on the same scale as the Q.2FRAC products.
    // prod_valid follows the beat by one edge, so the last product lands
    // during DRAIN without any special casing.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            beat_cnt   <= '0;
            acc        <= '0;
        end else begin
            prod_valid <= beat;
            if (beat) begin
                prod     <= $signed(in_x) * $signed(in_w);
                beat_cnt <= beat_cnt + CW'(1);
            end
            if (state == IDLE && start) begin
                acc      <= {{(ACCW - DWIDTH){bias[DWIDTH-1]}}, bias} << FRAC;
                beat_cnt <= '0;
            end else if (prod_valid) begin
                acc <= acc + {{(ACCW - PW){prod[PW-1]}}, prod};
            end
        end
    end

    // Rescale back to the input format. The arithmetic shift floors toward
    // minus infinity, which is what dropping the low fractional bits gives.
    assign shifted = acc >>> FRAC;

`ifdef PERCEPTRON_MAC_SAT_EN
    // The value fits in DWIDTH bits only when every bit from the result sign
    // bit upward is a copy of the same value; otherwise clamp by sign.
    always_comb begin
        result     = shifted[DWIDTH-1:0];
        result_sat = 1'b0;
        if (!((&shifted[ACCW-1:DWIDTH-1]) || !(|shifted[ACCW-1:DWIDTH-1]))) begin
            result_sat = 1'b1;
            if (shifted[ACCW-1]) begin
                result = {1'b1, {(DWIDTH - 1){1'b0}}};
            end else begin
                result = {1'b0, {(DWIDTH - 1){1'b1}}};
            end
        end
    end
`else
    // Wrap-around build: keep only the low DWIDTH bits of the rescaled sum.
    logic unused_upper;
    assign unused_upper = ^shifted[ACCW-1:DWIDTH];

    always_comb begin
        result     = shifted[DWIDTH-1:0];
        result_sat = 1'b0;
    end
`endif

    // Output register: captured once per operation in DONE, so out_data and
    // sat hold between results and out_valid is a single-cycle strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == DONE) begin
                out_data  <= result;
                sat       <= result_sat;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_perceptron_mac.sv
// tb_perceptron_mac
// ----------------------------------------------------------------------------
// Directed testbench for perceptron_mac (DWIDTH=32, FRAC=16, NINPUTS=4).
// Expected results are hand-computed fixed-point sums. Saturation
// expectations follow the PERCEPTRON_MAC_SAT_EN macro.
// ----------------------------------------------------------------------------
module tb_perceptron_mac;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_w;
    logic [31:0] out_data;
    logic        out_valid;
    logic        busy;
    logic        sat;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] BASIC_X = {32'h00010000, 32'h00008000, 32'h00030000, 32'hFFFE0000};
    localparam logic [127:0] BASIC_W = {32'h00020000, 32'hFFFF0000, 32'h00004000, 32'hFFFF8000};

    perceptron_mac #(
        .DWIDTH  (32),
        .FRAC    (16),
        .NINPUTS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .sat       (sat)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] b);
        start = 1'b1;
        bias  = b;
        tick();
        start = 1'b0;
        bias  = 32'hDEADBEEF;
    endtask

    task automatic send_beat(input logic [31:0] x, input logic [31:0] w);
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        tick();
        in_valid = 1'b0;
        in_x     = 32'hBAD0BAD0;
        in_w     = 32'h0BAD0BAD;
    endtask

    task automatic send_four(input logic [3:0][31:0] xs, input logic [3:0][31:0] ws);
        for (int i = 3; i >= 0; i--) begin
            send_beat(xs[i], ws[i]);
        end
    endtask

    task automatic wait_out(output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (out_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        bias     = '0;
        in_valid = 1'b0;
        in_x     = '0;
        in_w     = '0;
        tick();
        tick();
        checks++;
        if ({out_data, out_valid, in_ready, busy, sat} !== 36'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got data=%h v=%b rdy=%b busy=%b sat=%b expected all zero",
                     out_data, out_valid, in_ready, busy, sat);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: got busy=%b rdy=%b expected 0 0", busy, in_ready);
        end
    endtask

    task automatic test_basic_sum();
        int n;
        bit seen;
        start_op(32'h00008000);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_acc_entry: got busy=%b rdy=%b expected 1 1", busy, in_ready);
        end
        send_four(BASIC_X, BASIC_W);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_drain: got v=%b rdy=%b expected 0 0", out_valid, in_ready);
        end
        wait_out(n, seen);
        checks++;
        if (!seen || n != 2) begin
            failures++;
            $display("[TB] FAIL basic_latency: got seen=%b edges=%0d expected 1 2", seen, n);
        end
        checks++;
        if (out_data !== 32'h0003C000 || sat !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_result: got %h sat=%b expected 0003c000 sat=0", out_data, sat);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0003C000 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_strobe_hold: got v=%b data=%h busy=%b expected 0 0003c000 0",
                     out_valid, out_data, busy);
        end
    endtask

    task automatic test_truncation();
        int n;
        bit seen;
        // -2^-16 * 0.5 = -2^-17 must floor to -1 LSB, not truncate to zero.
        start_op(32'h00000000);
        send_four({32'hFFFFFFFF, 32'h0, 32'h0, 32'h0}, {32'h00008000, 32'h0, 32'h0, 32'h0});
        wait_out(n, seen);
        checks++;
        if (!seen || out_data !== 32'hFFFFFFFF) begin
            failures++;
            $display("[TB] FAIL floor_result: got seen=%b data=%h expected 1 ffffffff", seen, out_data);
        end
    endtask

    task automatic test_stalls();
        int n;
        bit seen;
        bit rdy_ok = 1'b1;
        start_op(32'h00008000);
        for (int i = 3; i >= 0; i--) begin
            for (int g = 0; g < 3; g++) begin
                in_valid = 1'b0;
                if (in_ready !== 1'b1) rdy_ok = 1'b0;
                tick();
            end
            if (in_ready !== 1'b1) rdy_ok = 1'b0;
            send_beat(BASIC_X[i*32 +: 32], BASIC_W[i*32 +: 32]);
        end
        checks++;
        if (!rdy_ok) begin
            failures++;
            $display("[TB] FAIL stall_ready: got in_ready low during ACC expected high throughout");
        end
        wait_out(n, seen);
        checks++;
        if (!seen || n != 2 || out_data !== 32'h0003C000) begin
            failures++;
            $display("[TB] FAIL stall_result: got seen=%b edges=%0d data=%h expected 1 2 0003c000",
                     seen, n, out_data);
        end
    endtask

    task automatic test_saturation();
        int n;
        bit seen;
        logic [31:0] exp_pos;
        logic [31:0] exp_neg;
        logic        exp_sat;
`ifdef PERCEPTRON_MAC_SAT_EN
        exp_pos = 32'h7FFFFFFF;
        exp_neg = 32'h80000000;
        exp_sat = 1'b1;
`else
        exp_pos = 32'h00040000;
        exp_neg = 32'hFFFC0000;
        exp_sat = 1'b0;
`endif
        start_op(32'h00000000);
        send_four({4{32'h7FFF0000}}, {4{32'h7FFF0000}});
        wait_out(n, seen);
        checks++;
        if (!seen || out_data !== exp_pos || sat !== exp_sat) begin
            failures++;
            $display("[TB] FAIL sat_positive: got seen=%b data=%h sat=%b expected 1 %h %b",
                     seen, out_data, sat, exp_pos, exp_sat);
        end
        tick();
        start_op(32'h00000000);
        send_four({4{32'h80010000}}, {4{32'h7FFF0000}});
        wait_out(n, seen);
        checks++;
        if (!seen || out_data !== exp_neg || sat !== exp_sat) begin
            failures++;
            $display("[TB] FAIL sat_negative: got seen=%b data=%h sat=%b expected 1 %h %b",
                     seen, out_data, sat, exp_neg, exp_sat);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        bit spurious = 1'b0;
        start_op(32'h00008000);
        send_beat(BASIC_X[96 +: 32], BASIC_W[96 +: 32]);
        send_beat(BASIC_X[64 +: 32], BASIC_W[64 +: 32]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_state: got busy=%b rdy=%b data=%h v=%b expected 0 0 0 0",
                     busy, in_ready, out_data, out_valid);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid !== 1'b0) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            failures++;
            $display("[TB] FAIL midreset_no_valid: got out_valid=1 expected none after reset");
        end
        start_op(32'h00008000);
        send_four(BASIC_X, BASIC_W);
        wait_out(n, seen);
        checks++;
        if (!seen || out_data !== 32'h0003C000) begin
            failures++;
            $display("[TB] FAIL midreset_rerun: got seen=%b data=%h expected 1 0003c000", seen, out_data);
        end
    endtask

    task automatic test_start_ignored();
        int n;
        bit seen;
        start_op(32'h00008000);
        send_beat(BASIC_X[96 +: 32], BASIC_W[96 +: 32]);
        send_beat(BASIC_X[64 +: 32], BASIC_W[64 +: 32]);
        start = 1'b1;
        bias  = 32'h7FFF0000;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL start_in_acc: got busy=%b rdy=%b expected 1 1", busy, in_ready);
        end
        send_beat(BASIC_X[32 +: 32], BASIC_W[32 +: 32]);
        send_beat(BASIC_X[0 +: 32], BASIC_W[0 +: 32]);
        start = 1'b1;
        bias  = 32'h7FFF0000;
        wait_out(n, seen);
        start = 1'b0;
        checks++;
        if (!seen || n != 2 || out_data !== 32'h0003C000 || sat !== 1'b0) begin
            failures++;
            $display("[TB] FAIL start_ignored: got seen=%b edges=%0d data=%h sat=%b expected 1 2 0003c000 0",
                     seen, n, out_data, sat);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int total;
        bit seen;
        start_op(32'h00008000);
        send_four(BASIC_X, BASIC_W);
        wait_out(n, seen);
        checks++;
        if (!seen || out_data !== 32'h0003C000) begin
            failures++;
            $display("[TB] FAIL b2b_first: got seen=%b data=%h expected 1 0003c000", seen, out_data);
        end
        // Second operation: 1 + 2*3 - 1*1 + 0.25*4 + 1.5*2 = 10.0
        start_op(32'h00010000);
        total = 1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_accept: got busy=%b expected 1", busy);
        end
        send_four({32'h00020000, 32'hFFFF0000, 32'h00004000, 32'h00018000},
                  {32'h00030000, 32'h00010000, 32'h00040000, 32'h00020000});
        total += 4;
        wait_out(n, seen);
        total += n;
        checks++;
        if (!seen || total != 7) begin
            failures++;
            $display("[TB] FAIL b2b_spacing: got seen=%b cycles=%0d expected 1 7", seen, total);
        end
        checks++;
        if (out_data !== 32'h000A0000 || sat !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_second: got %h sat=%b expected 000a0000 0", out_data, sat);
        end
    endtask

    // Scenario sequence; every task starts and ends in IDLE.
    initial begin
        test_reset();
        test_basic_sum();
        test_truncation();
        test_stalls();
        test_saturation();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perceptron_mac.md
# perceptron_mac

Sequential multiply-accumulate stage for one perceptron. It accepts NINPUTS signed fixed-point (input, weight) pairs over a valid/ready stream and accumulates their products onto a bias. It then emits the weighted sum with a one-cycle `out_valid` strobe. It sits directly upstream of the neuron's output register: `out_data` drives that register's data input and `out_valid` drives its enable.

## Interface
- `DWIDTH`, 32: width of inputs, weights, bias and result (signed, two's complement).
- `FRAC`, 16: fractional bits of the fixed-point format (Q(DWIDTH-FRAC).FRAC).
- `NINPUTS`, 4: number of (x, w) pairs per operation; must be ≥1.
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `start` input 1: begin an operation; sampled only in IDLE.
- `bias` input DWIDTH: bias, sampled on the edge that accepts `start`.
- `in_valid` input 1: `in_x`/`in_w` hold a valid pair.
- `in_ready` output 1: stage accepts a pair this cycle.
- `in_x` input DWIDTH: neuron input.
- `in_w` input DWIDTH: weight.
- `out_data` output DWIDTH: result; holds its value until the next result.
- `out_valid` output 1: one-cycle strobe, result is valid.
- `busy` output 1: high in every state except IDLE.
- `sat` output 1: the current `out_data` was clamped; valid whenever `out_data` is.

## Operation
- FSM states: IDLE, ACC, DRAIN, DONE.
- IDLE:
  - `in_ready`=0.
  - On `start`=1: load accumulator = sign-extended `bias` << FRAC, clear beat counter, go to ACC.
- ACC:
  - `in_ready`=1.
  - Beat = `in_valid` & `in_ready`; each beat increments the counter.
  - Gaps (`in_valid`=0) are allowed indefinitely.
  - On the NINPUTS-th beat, go to DRAIN.
- DRAIN: `in_ready`=0; stays one cycle while the last product reaches the accumulator; then go to DONE.
- DONE: register the result, pulse `out_valid`, return to IDLE.
- `start` outside IDLE is ignored and has no effect on the running operation.
- Arithmetic:
  - Product: full 2·DWIDTH signed, registered one stage.
  - Accumulator: 2·DWIDTH+clog2(NINPUTS)+1 bits, so it never overflows internally.
  - Result: accumulator >>> FRAC (arithmetic shift, truncation toward −∞), then reduced to DWIDTH (see Configuration).
- Reset values: `out_data`=0, `out_valid`=0, `in_ready`=0, `busy`=0, `sat`=0, FSM=IDLE, accumulator and counter=0.
- Reset mid-operation: the partial sum is discarded and no `out_valid` is produced.

## Timing
- Product register: the edge that accepts beat k registers x·w; the next edge adds it to the accumulator.
- Last-beat latency: `out_valid`, `out_data` and `sat` update on the 2nd rising edge after the edge that accepts the NINPUTS-th beat.
- Minimum operation length: NINPUTS+3 cycles from the `start` edge to the `out_valid` edge.
- Back-to-back: the next `start` may be accepted in the cycle following `out_valid`.
- `out_valid` is high for exactly one cycle and has no backpressure.

## Configuration
- `PERCEPTRON_MAC_SAT_EN` defined:
  - Result is clamped to [−2^(DWIDTH−1), 2^(DWIDTH−1)−1], i.e. 0x80000000 / 0x7FFFFFFF for DWIDTH=32.
  - `sat`=1 when the clamp is applied.
- Macro not defined: result is the low DWIDTH bits (wrap-around), and `sat` is tied to 0.

## Test plan
- Basic sum (FRAC=16, NINPUTS=4): bias 0x00008000, pairs (0x00010000,0x00020000), (0x00008000,0xFFFF0000), (0x00030000,0x00004000), (0xFFFE0000,0xFFFF8000) -> `out_data`=0x0003C000, `sat`=0, one-cycle `out_valid` 2 edges after the last beat.
- Stalls: same data with `in_valid` deasserted for 3 cycles between beats -> identical result; `in_ready` stays high throughout ACC.
- Saturation: bias 0, four pairs (0x7FFF0000,0x7FFF0000) -> macro on: 0x7FFFFFFF, `sat`=1; macro off: 0x00040000, `sat`=0. Four pairs (0x80010000,0x7FFF0000) with macro on -> 0x80000000, `sat`=1.
- Reset after 2 of 4 beats -> next cycle `busy`=0, `in_ready`=0, `out_data`=0, no `out_valid`; a following full basic-sum operation -> 0x0003C000.
- `start` pulsed with bias 0x7FFF0000 during ACC and during DRAIN -> ignored; result equals the basic-sum value.
- Back-to-back: `start` in the cycle after `out_valid` -> accepted; second result correct and its `out_valid` is exactly NINPUTS+3 cycles later with no stalls.
